// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB port scheduler and the BTB storage.
//   XLEN       : address width
//   ENTRIES    : number of BTB entries covered by an invalidate sweep
//   IDX_W      : entry index width
//   QDEPTH     : resolve-queue depth (power of two, >= 2)
//   STARVE_LIM : consecutive fetch wins before a pending update is forced
package btb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ENTRIES    = 2048;
    localparam int unsigned IDX_W      = $clog2(ENTRIES);
    localparam int unsigned QDEPTH     = 4;
    localparam int unsigned STARVE_LIM = 8;
    localparam int unsigned CNT_W      = $clog2(QDEPTH) + 1;
    localparam int unsigned STARVE_W   = $clog2(STARVE_LIM + 1);

    // One resolved-branch update as written into the BTB.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            taken;
    } btb_upd_t;

    typedef enum logic [0:0] {
        StSweep,
        StRun
    } sched_state_e;

endpackage

// File: rtl/btb_port_sched_if.sv
// Bundle of all fetch/execute/flush/BTB-side signals of the port scheduler.
//   slave  : scheduler view (requests in, grants/strobes/redirect out)
//   master : environment view (drives requests, observes scheduler outputs)
interface btb_port_sched_if;
    import btb_pkg::*;

    logic             fetch_req;
    logic [XLEN-1:0]  fetch_addr;
    logic             fetch_gnt;
    logic             res_valid;
    logic             res_ready;
    logic [XLEN-1:0]  res_pc;
    logic [XLEN-1:0]  res_target;
    logic             res_taken;
    logic             res_mispred;
    logic             flush_req;
    logic             flush_busy;
    logic             btb_rd_en;
    logic [XLEN-1:0]  btb_rd_addr;
    logic             btb_wr_en;
    logic [XLEN-1:0]  btb_wr_pc;
    logic [XLEN-1:0]  btb_wr_target;
    logic             btb_wr_taken;
    logic             btb_inv_en;
    logic [IDX_W-1:0] btb_inv_idx;
    logic             redirect;
    logic [XLEN-1:0]  redirect_addr;
    logic [CNT_W-1:0] q_count;

    modport slave (
        input  fetch_req, fetch_addr, res_valid, res_pc, res_target, res_taken,
               res_mispred, flush_req,
        output fetch_gnt, res_ready, flush_busy, btb_rd_en, btb_rd_addr, btb_wr_en,
               btb_wr_pc, btb_wr_target, btb_wr_taken, btb_inv_en, btb_inv_idx,
               redirect, redirect_addr, q_count
    );

    modport master (
        output fetch_req, fetch_addr, res_valid, res_pc, res_target, res_taken,
               res_mispred, flush_req,
        input  fetch_gnt, res_ready, flush_busy, btb_rd_en, btb_rd_addr, btb_wr_en,
               btb_wr_pc, btb_wr_target, btb_wr_taken, btb_inv_en, btb_inv_idx,
               redirect, redirect_addr, q_count
    );

endinterface

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO of BTB updates with occupancy output and synchronous clear.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : drop all entries (wins over push/pop)
//   push_i/data_i : enqueue (ignored when full)
//   pop_i/data_o  : dequeue / head entry (pop ignored when empty)
//   count_o, empty_o, full_o : occupancy status
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int unsigned Depth = QDEPTH,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            push_i,
    input  btb_upd_t        data_i,
    input  logic            pop_i,
    output btb_upd_t        data_o,
    output logic [CntW-1:0] count_o,
    output logic            empty_o,
    output logic            full_o
);

    btb_upd_t        mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o && !clr_i;
    assign pop_ok  = pop_i && !empty_o && !clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Depth is a power of two, so pointers wrap by overflow.
            if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push_ok && !pop_ok)      count_d = count_q + CntW'(1);
            else if (pop_ok && !push_ok) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only slots below count are ever read out.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/btb_port_sched.sv
// Arbitrates the single BTB access port between fetch lookups, queued
// resolved-branch updates and a full-table invalidate sweep; also issues the
// registered fetch redirect after a mispredicted branch is accepted.
//   clk : clock
//   rst : asynchronous active-low reset (starts a full sweep)
//   bus : fetch request/grant, resolve handshake, flush, BTB strobes,
//         redirect and queue occupancy (see btb_port_sched_if)
module btb_port_sched
    import btb_pkg::*;
(
    input logic             clk,
    input logic             rst,
    btb_port_sched_if.slave bus
);

    localparam logic [IDX_W-1:0]    LastIdx   = IDX_W'(ENTRIES - 1);
    localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_LIM);

    sched_state_e        state_q, state_d;
    logic [IDX_W-1:0]    inv_idx_q, inv_idx_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                redirect_q, redirect_d;
    logic [XLEN-1:0]     redirect_addr_q, redirect_addr_d;

    logic             fetch_gnt, rd_en, wr_sel, wr_en, inv_en;
    logic             flush_busy, res_ready, res_hs, q_clr;
    logic             q_empty, q_full;
    logic [CNT_W-1:0] q_cnt;
    btb_upd_t         q_head, q_in;

    assign q_in   = '{pc: bus.res_pc, target: bus.res_target, taken: bus.res_taken};
    assign res_hs = bus.res_valid && res_ready;

    btb_upd_fifo #(
        .Depth (QDEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clr_i   (q_clr),
        // An entry offered in the flush cycle is dropped with the rest.
        .push_i  (res_hs && !bus.flush_req),
        .data_i  (q_in),
        .pop_i   (wr_en),
        .data_o  (q_head),
        .count_o (q_cnt),
        .empty_o (q_empty),
        .full_o  (q_full)
    );

    always_comb begin
        state_d         = state_q;
        inv_idx_d       = inv_idx_q;
        starve_d        = starve_q;
        redirect_d      = 1'b0;
        redirect_addr_d = redirect_addr_q;
        fetch_gnt       = 1'b0;
        rd_en           = 1'b0;
        wr_sel          = 1'b0;
        wr_en           = 1'b0;
        inv_en          = 1'b0;
        flush_busy      = 1'b0;
        res_ready       = 1'b0;
        q_clr           = 1'b0;

        unique case (state_q)
            StSweep: begin
                // Gated by rst so no strobe leaks out while reset is held.
                inv_en     = rst;
                flush_busy = 1'b1;
                inv_idx_d  = inv_idx_q + IDX_W'(1);
                if (inv_idx_q == LastIdx) begin
                    state_d   = StRun;
                    inv_idx_d = '0;
                end
            end
            StRun: begin
                res_ready = !q_full;
                if (!q_empty && (q_full || starve_q == StarveMax)) begin
                    wr_sel = 1'b1;
                end else if (bus.fetch_req && !redirect_q) begin
                    fetch_gnt = 1'b1;
                    rd_en     = 1'b1;
                end else if (!q_empty) begin
                    wr_sel = 1'b1;
                end
                // A flush discards the queue, so its head is not written either.
                wr_en = wr_sel && !bus.flush_req;
                if (bus.flush_req) begin
                    state_d   = StSweep;
                    inv_idx_d = '0;
                    q_clr     = 1'b1;
                end
            end
            default: state_d = StSweep;
        endcase

        if (q_empty || wr_en || q_clr) begin
            starve_d = '0;
        end else if (fetch_gnt && starve_q != StarveMax) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        if (res_hs && bus.res_mispred) begin
            redirect_d      = 1'b1;
            redirect_addr_d = bus.res_taken ? bus.res_target : bus.res_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StSweep;
            inv_idx_q       <= '0;
            starve_q        <= '0;
            redirect_q      <= 1'b0;
            redirect_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            inv_idx_q       <= inv_idx_d;
            starve_q        <= starve_d;
            redirect_q      <= redirect_d;
            redirect_addr_q <= redirect_addr_d;
        end
    end

    assign bus.fetch_gnt     = fetch_gnt;
    assign bus.res_ready     = res_ready;
    assign bus.flush_busy    = flush_busy;
    assign bus.btb_rd_en     = rd_en;
    assign bus.btb_rd_addr   = bus.fetch_addr;
    assign bus.btb_wr_en     = wr_en;
    assign bus.btb_wr_pc     = q_head.pc;
    assign bus.btb_wr_target = q_head.target;
    assign bus.btb_wr_taken  = q_head.taken;
    assign bus.btb_inv_en    = inv_en;
    assign bus.btb_inv_idx   = inv_idx_q;
    assign bus.redirect      = redirect_q;
    assign bus.redirect_addr = redirect_addr_q;
    assign bus.q_count       = q_cnt;

endmodule

// File: tb/tb_btb_port_sched.sv
module tb_btb_port_sched;
    import btb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    btb_port_sched_if bif ();

    btb_port_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int n_assert = 0;
    int n_fail   = 0;
    btb_upd_t sb[$];

    logic [XLEN-1:0] s_gnt, s_ready, s_busy, s_rd, s_wr, s_inv, s_redir, s_taken;
    logic [XLEN-1:0] s_rd_addr, s_wr_pc, s_wr_tgt, s_redir_addr, s_idx, s_cnt;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score writes, update the model, move past posedge.
    task automatic cyc();
        btb_upd_t e;
        @(negedge clk);
        s_gnt        = XLEN'(bif.fetch_gnt);
        s_ready      = XLEN'(bif.res_ready);
        s_busy       = XLEN'(bif.flush_busy);
        s_rd         = XLEN'(bif.btb_rd_en);
        s_wr         = XLEN'(bif.btb_wr_en);
        s_inv        = XLEN'(bif.btb_inv_en);
        s_redir      = XLEN'(bif.redirect);
        s_taken      = XLEN'(bif.btb_wr_taken);
        s_rd_addr    = bif.btb_rd_addr;
        s_wr_pc      = bif.btb_wr_pc;
        s_wr_tgt     = bif.btb_wr_target;
        s_redir_addr = bif.redirect_addr;
        s_idx        = XLEN'(bif.btb_inv_idx);
        s_cnt        = XLEN'(bif.q_count);
        chk("strobe_onehot0", XLEN'(s_rd + s_wr + s_inv > 1), 0);
        if (s_wr == 1) begin
            chk("wr_with_empty_model", XLEN'(sb.size() == 0), 0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_pc", s_wr_pc, e.pc);
                chk("wr_target", s_wr_tgt, e.target);
                chk("wr_taken", s_taken, XLEN'(e.taken));
            end
        end
        if (bif.flush_req && s_busy == 0) begin
            sb.delete();
        end else if (bif.res_valid && s_ready == 1) begin
            e = '{pc: bif.res_pc, target: bif.res_target, taken: bif.res_taken};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                         input logic tk, input logic mp);
        bif.res_valid   = 1'b1;
        bif.res_pc      = pc;
        bif.res_target  = tgt;
        bif.res_taken   = tk;
        bif.res_mispred = mp;
    endtask

    initial begin
        bif.fetch_req   = 1'b0;
        bif.fetch_addr  = '0;
        bif.res_valid   = 1'b0;
        bif.res_pc      = '0;
        bif.res_target  = '0;
        bif.res_taken   = 1'b0;
        bif.res_mispred = 1'b0;
        bif.flush_req   = 1'b0;

        // Reset held: everything quiet.
        cyc();
        chk("rst_inv_en", s_inv, 0);
        chk("rst_rd_en", s_rd, 0);
        chk("rst_wr_en", s_wr, 0);
        chk("rst_redirect", s_redir, 0);
        chk("rst_redirect_addr", s_redir_addr, 0);
        chk("rst_q_count", s_cnt, 0);
        rst = 1'b1;

        // Initial sweep: requests offered but never accepted.
        bif.fetch_req = 1'b1;
        offer(32'hDEAD_0000, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < ENTRIES; i++) begin
            cyc();
            chk("sweep_inv_en", s_inv, 1);
            chk("sweep_idx", s_idx, XLEN'(i));
            chk("sweep_res_ready", s_ready, 0);
            chk("sweep_fetch_gnt", s_gnt, 0);
            chk("sweep_busy", s_busy, 1);
        end
        bif.res_valid  = 1'b0;
        bif.res_mispred = 1'b0;
        bif.fetch_addr = 32'h1000;
        cyc();
        chk("run_busy", s_busy, 0);
        chk("run_res_ready", s_ready, 1);
        chk("run_fetch_gnt", s_gnt, 1);
        chk("run_rd_en", s_rd, 1);
        chk("run_rd_addr", s_rd_addr, 32'h1000);
        chk("run_redirect_idle", s_redir, 0);

        // Idle-slot update one cycle after enqueue.
        bif.fetch_req = 1'b0;
        offer(32'h2000, 32'h2100, 1'b1, 1'b0);
        cyc();
        chk("enq_wr_en", s_wr, 0);
        bif.res_valid = 1'b0;
        cyc();
        chk("idle_wr_en", s_wr, 1);
        chk("idle_wr_pc", s_wr_pc, 32'h2000);

        // Fill the queue under continuous fetch; full forces a write.
        bif.fetch_req  = 1'b1;
        bif.fetch_addr = 32'h1100;
        for (int k = 0; k < QDEPTH; k++) begin
            offer(32'h5000 + 32'(k * 16), 32'h5040 + 32'(k * 16), k[0], 1'b0);
            cyc();
            chk("fill_ready", s_ready, 1);
            chk("fill_gnt", s_gnt, 1);
        end
        offer(32'h6000, 32'h6040, 1'b0, 1'b0);
        cyc();
        chk("full_ready", s_ready, 0);
        chk("full_q_count", s_cnt, QDEPTH);
        chk("full_forced_wr", s_wr, 1);
        chk("full_forced_gnt", s_gnt, 0);
        chk("full_forced_pc", s_wr_pc, 32'h5000);
        bif.res_valid = 1'b0;
        bif.fetch_req = 1'b0;
        for (int k = 0; k < QDEPTH - 1; k++) cyc();
        cyc();
        chk("drain_q_count", s_cnt, 0);
        chk("drain_wr_en", s_wr, 0);
        chk("drain_model_empty", XLEN'(sb.size()), 0);

        // Starvation: eight fetch wins, then one forced write.
        bif.fetch_req = 1'b1;
        offer(32'h7000, 32'h7700, 1'b1, 1'b0);
        cyc();
        bif.res_valid = 1'b0;
        for (int j = 0; j < STARVE_LIM; j++) begin
            cyc();
            chk("starve_gnt", s_gnt, 1);
            chk("starve_no_wr", s_wr, 0);
        end
        cyc();
        chk("starve_forced_wr", s_wr, 1);
        chk("starve_forced_gnt", s_gnt, 0);
        cyc();
        chk("starve_after_gnt", s_gnt, 1);

        // Mispredict, not taken: redirect to pc+4.
        offer(32'h3000, 32'h9990, 1'b0, 1'b1);
        cyc();
        chk("mp_same_cycle_redirect", s_redir, 0);
        bif.res_valid   = 1'b0;
        bif.res_mispred = 1'b0;
        cyc();
        chk("mp_nt_redirect", s_redir, 1);
        chk("mp_nt_addr", s_redir_addr, 32'h3004);
        chk("mp_nt_gnt", s_gnt, 0);
        chk("mp_nt_slot_wr", s_wr, 1);
        cyc();
        chk("mp_pulse_end", s_redir, 0);
        chk("mp_addr_hold", s_redir_addr, 32'h3004);
        chk("mp_gnt_back", s_gnt, 1);

        // Back-to-back mispredicts: taken target, then pc+4 wrapping past 2^32.
        offer(32'h3100, 32'h4000, 1'b1, 1'b1);
        cyc();
        offer(32'hFFFF_FFFC, 32'h1234, 1'b0, 1'b1);
        cyc();
        chk("b2b_first_redirect", s_redir, 1);
        chk("b2b_first_addr", s_redir_addr, 32'h4000);
        chk("b2b_first_gnt", s_gnt, 0);
        bif.res_valid   = 1'b0;
        bif.res_mispred = 1'b0;
        cyc();
        chk("b2b_second_redirect", s_redir, 1);
        chk("b2b_second_addr", s_redir_addr, 32'h0);
        cyc();
        chk("b2b_end_redirect", s_redir, 0);
        chk("b2b_end_gnt", s_gnt, 1);

        // Flush with two queued entries: queue dropped, sweep restarts at 0.
        offer(32'h8000, 32'h8800, 1'b0, 1'b0);
        cyc();
        offer(32'h8010, 32'h8810, 1'b1, 1'b0);
        cyc();
        bif.res_valid = 1'b0;
        bif.flush_req = 1'b1;
        cyc();
        chk("flush_q_count_before", s_cnt, 2);
        chk("flush_cycle_wr", s_wr, 0);
        bif.flush_req = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            bif.flush_req = (i == 100);
            cyc();
            if (i == 0) begin
                chk("flush_q_count_after", s_cnt, 0);
                chk("flush_busy", s_busy, 1);
            end
            chk("resweep_inv_en", s_inv, 1);
            chk("resweep_idx", s_idx, XLEN'(i));
        end
        bif.flush_req = 1'b0;
        cyc();
        chk("resweep_done_busy", s_busy, 0);
        chk("resweep_done_q_count", s_cnt, 0);
        chk("resweep_done_gnt", s_gnt, 1);
        chk("resweep_done_wr", s_wr, 0);

        // Asynchronous reset with a queued entry and a pending redirect.
        offer(32'hA000, 32'hB000, 1'b1, 1'b1);
        cyc();
        bif.res_valid   = 1'b0;
        bif.res_mispred = 1'b0;
        chk("pre_rst_redirect", XLEN'(bif.redirect), 1);
        chk("pre_rst_q_count", XLEN'(bif.q_count), 1);
        #2;
        rst = 1'b0;
        #1;
        sb.delete();
        chk("async_rst_q_count", XLEN'(bif.q_count), 0);
        chk("async_rst_redirect", XLEN'(bif.redirect), 0);
        chk("async_rst_redirect_addr", bif.redirect_addr, 0);
        chk("async_rst_inv_en", XLEN'(bif.btb_inv_en), 0);
        chk("async_rst_rd_en", XLEN'(bif.btb_rd_en), 0);
        chk("async_rst_wr_en", XLEN'(bif.btb_wr_en), 0);
        chk("async_rst_gnt", XLEN'(bif.fetch_gnt), 0);
        chk("async_rst_busy", XLEN'(bif.flush_busy), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
